ls_queue_fwd: RTL and testbench
===============================

LS_QUEUE_FWD -- requirements
Module: ls_queue_fwd

Interface
REQ-001 Parameter: DEPTH, 8, number of queue entries; power of 2, range 2..64.
REQ-002 Parameter: XLEN, 32, data width in bits.
REQ-003 Parameter: AW, 32, address width in bits.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk_in  in  1  clock; all state updates on its rising edge.
REQ-006 reset_in  in  1  synchronous active-high reset.
REQ-007 enq_valid  in  1  MEM stage presents a load or store for allocation.
REQ-008 enq_rdy  out  1  queue can accept an entry; equals (count < DEPTH).
REQ-009 enq_is_ld  in  1  1 = load, 0 = store.
REQ-010 enq_addr  in  AW  byte address.
REQ-011 enq_data  in  XLEN  store data, right-justified; ignored for loads.
REQ-012 enq_size  in  3  access size in bytes: 1, 2 or 4.
REQ-013 enq_zero_ext  in  1  load zero-extends when 1, sign-extends when 0.
REQ-014 cm_valid  in  1  WB commits the oldest uncommitted entry.
REQ-015 flush_in  in  1  discard all uncommitted entries.
REQ-016 dc_req  out  1  request to L1 D$; fields below held stable until dc_ack.
REQ-017 dc_wr, dc_addr, dc_wdata, dc_size  out  1/AW/XLEN/3  request fields.
REQ-018 dc_ack  in  1  D$ completes the request this cycle.
REQ-019 dc_rdata  in  XLEN  extended load data, valid with dc_ack.
REQ-020 dc_fault  in  1  access fault, valid with dc_ack.
REQ-021 ld_valid, ld_data, ld_fault  out  1/XLEN/1  one-cycle load-result pulse, in issue order.

Function
REQ-022 Entry fields: valid, is_ld, addr, data, size, zero_ext, committed, completed, fault; pointers head, tail, cm (each clog2(DEPTH) bits, wrap modulo DEPTH); count is clog2(DEPTH)+1 bits.
REQ-023 Allocation occurs on enq_valid & enq_rdy: write at tail, tail+1, committed=0, completed=0.
REQ-024 A cm_valid pulse sets committed at cm and advances cm; it is ignored when cm==tail.
REQ-025 Retire: the head entry leaves the queue when completed & committed, at most one per cycle; allocation and retirement in the same cycle leave count unchanged.
REQ-026 Store eligibility: committed, not completed, and all older stores completed; stores therefore reach D$ in program order.
REQ-027 Load conflict store: the youngest older store still in the queue with addr[AW-1:2] equal to the load's.
REQ-028 Load with no conflict store: eligible for D$.
REQ-029 Load whose conflict store has identical addr and size >= load size: eligible for forwarding.
REQ-030 Load whose conflict store does not meet REQ-029: stalls until that store retires.
REQ-031 Forwarded data is the low size bytes of the store data, zero- or sign-extended per zero_ext.
REQ-032 Issue selects the oldest eligible entry; FSM states IDLE and WAIT_ACK.
REQ-033 IDLE, forward case: mark the load completed; pulse ld_valid with the forwarded data on the next cycle; remain in IDLE; dc_req stays 0.
REQ-034 IDLE, D$ case: assert dc_req with the selected entry's fields and go to WAIT_ACK.
REQ-035 WAIT_ACK: hold dc_req and its fields; on dc_ack, mark the entry completed and record dc_fault, then return to IDLE.
REQ-036 Load completion by D$: pulse ld_valid/ld_data/ld_fault on the cycle after dc_ack.
REQ-037 flush_in: tail <= cm; count <= number of committed entries; flushed entries become invalid. Flush takes priority over a same-cycle allocation; a same-cycle cm_valid is applied before the flush.
REQ-038 Flush during WAIT_ACK of a flushed load: finish the handshake, discard the result, no ld_valid. A committed store is never flushed.
REQ-039 Sizes other than 1, 2 or 4 are treated as 4.

Reset
REQ-040 On reset_in: head=tail=cm=0, count=0, all entries invalid, state=IDLE; dc_req=0, ld_valid=0, ld_fault=0, enq_rdy=1. Reset mid-WAIT_ACK drops the request.

Verification
REQ-041 Store 0x100 size4 data 0xDEADBEEF, then load 0x100 size1 sign-extended, store uncommitted -> ld_valid with 0xFFFFFFEF, no dc_req for the load.
REQ-042 Store 0x100 size1, then load 0x100 size4 -> load stalls; commit store; dc_ack; store retires; load then issues dc_req with addr 0x100.
REQ-043 Fill 8 entries -> enq_rdy=0; commit and complete head -> enq_rdy=1 next cycle; tail wraps to 0.
REQ-044 Three uncommitted loads queued; flush_in while the first is in WAIT_ACK -> count=0 after flush; ack finishes the handshake with no ld_valid.
REQ-045 Load with dc_fault=1 on ack -> ld_valid=1, ld_fault=1 next cycle; the entry retires after commit.
REQ-046 Assert reset_in during WAIT_ACK -> next cycle dc_req=0, count=0, enq_rdy=1.

Source files
------------

// File: rtl/ls_queue_fwd.sv
// ls_queue_fwd: in-order load/store queue with store-to-load forwarding and a single D$ port.
// Ports: clk_in/reset_in (sync active-high); enq_* allocate a load/store from MEM;
// cm_valid commits the oldest uncommitted entry; flush_in drops uncommitted entries;
// dc_* is a req/ack D$ interface held stable until dc_ack; ld_* pulses load results in issue order.
module ls_queue_fwd #(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32,
   parameter int AW    = 32
) (
   input  logic            clk_in,
   input  logic            reset_in,
   input  logic            enq_valid,
   output logic            enq_rdy,
   input  logic            enq_is_ld,
   input  logic [AW-1:0]   enq_addr,
   input  logic [XLEN-1:0] enq_data,
   input  logic [2:0]      enq_size,
   input  logic            enq_zero_ext,
   input  logic            cm_valid,
   input  logic            flush_in,
   output logic            dc_req,
   output logic            dc_wr,
   output logic [AW-1:0]   dc_addr,
   output logic [XLEN-1:0] dc_wdata,
   output logic [2:0]      dc_size,
   input  logic            dc_ack,
   input  logic [XLEN-1:0] dc_rdata,
   input  logic            dc_fault,
   output logic            ld_valid,
   output logic [XLEN-1:0] ld_data,
   output logic            ld_fault
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   typedef enum logic {IDLE, WAIT_ACK} state_t;
   state_t          state_q, state_d;
   logic [DEPTH-1:0] v_q, v_d, ld_q, ld_d, zx_q, zx_d, cmt_q, cmt_d, cpl_q, cpl_d;
   logic [AW-1:0]   addr_q [DEPTH];
   logic [AW-1:0]   addr_d [DEPTH];
   logic [XLEN-1:0] data_q [DEPTH];
   logic [XLEN-1:0] data_d [DEPTH];
   logic [2:0]      size_q [DEPTH];
   logic [2:0]      size_d [DEPTH];
   logic [IW-1:0]   head_q, head_d, tail_q, tail_d, cm_q, cm_d, idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            kill_q, kill_d, kill_now, alloc, ret;
   logic            wr_q, wr_d, ldv_q, ldv_d, ldf_q, ldf_d;
   logic [AW-1:0]   a_q, a_d;
   logic [XLEN-1:0] wd_q, wd_d, ldd_q, ldd_d;
   logic [2:0]      sz_q, sz_d;
   logic            found, fwd, hit, el, pend;
   logic [IW-1:0]   sel, fsrc, ci, cj, cf;

   function automatic logic [3:0] nsz(input logic [2:0] s);
      return (s == 3'd1) ? 4'd1 : (s == 3'd2) ? 4'd2 : 4'd4;
   endfunction

   function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] d, input logic [2:0] s, input logic z);
      return (nsz(s) == 4'd1) ? {{(XLEN-8){~z & d[7]}}, d[7:0]} :
             (nsz(s) == 4'd2) ? {{(XLEN-16){~z & d[15]}}, d[15:0]} : d;
   endfunction

   assign enq_rdy  = cnt_q < CW'(DEPTH);
   assign dc_req   = state_q == WAIT_ACK;
   assign dc_wr    = wr_q;
   assign dc_addr  = a_q;
   assign dc_wdata = wd_q;
   assign dc_size  = sz_q;
   assign ld_valid = ldv_q;
   assign ld_data  = ldd_q;
   assign ld_fault = ldf_q;

   // Age-ordered scan from head: oldest eligible entry wins; a load's conflict is the
   // youngest older valid store to the same word.
   always_comb begin
      found = 1'b0;
      fwd   = 1'b0;
      sel   = '0;
      fsrc  = '0;
      pend  = 1'b0;
      ci    = '0;
      cj    = '0;
      cf    = '0;
      hit   = 1'b0;
      el    = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         ci  = head_q + IW'(k);
         hit = 1'b0;
         cf  = '0;
         for (int m = 0; m < DEPTH; m++) begin
            cj = head_q + IW'(m);
            if (m < k && v_q[cj] && !ld_q[cj] && addr_q[cj][AW-1:2] == addr_q[ci][AW-1:2]) begin
               hit = 1'b1;
               cf  = cj;
            end
         end
         el = v_q[ci] && !cpl_q[ci] &&
              (ld_q[ci] ? (!hit || (addr_q[cf] == addr_q[ci] && nsz(size_q[cf]) >= nsz(size_q[ci])))
                        : (cmt_q[ci] && !pend));
         if (v_q[ci] && !ld_q[ci] && !cpl_q[ci]) pend = 1'b1;
         if (el && !found) begin
            found = 1'b1;
            sel   = ci;
            fwd   = ld_q[ci] && hit;
            fsrc  = cf;
         end
      end
   end

   always_comb begin
      v_d = v_q; ld_d = ld_q; zx_d = zx_q; cmt_d = cmt_q; cpl_d = cpl_q;
      addr_d = addr_q; data_d = data_q; size_d = size_q;
      head_d = head_q; tail_d = tail_q; cm_d = cm_q; cnt_d = cnt_q;
      state_d = state_q; idx_d = idx_q; kill_d = kill_q;
      wr_d = wr_q; a_d = a_q; wd_d = wd_q; sz_d = sz_q;
      ldv_d = 1'b0; ldd_d = ldd_q; ldf_d = 1'b0;
      alloc = enq_valid && enq_rdy && !flush_in;
      ret = v_q[head_q] && cpl_q[head_q] && cmt_q[head_q];
      // Checking the entry rather than cm==tail keeps a full, uncommitted queue committable.
      if (cm_valid && v_q[cm_q] && !cmt_q[cm_q]) begin
         cmt_d[cm_q] = 1'b1;
         cm_d = cm_q + 1'b1;
      end
      if (ret) begin
         v_d[head_q] = 1'b0;
         head_d = head_q + 1'b1;
      end
      if (alloc) begin
         v_d[tail_q] = 1'b1; ld_d[tail_q] = enq_is_ld; zx_d[tail_q] = enq_zero_ext;
         cmt_d[tail_q] = 1'b0; cpl_d[tail_q] = 1'b0;
         addr_d[tail_q] = enq_addr; data_d[tail_q] = enq_data; size_d[tail_q] = enq_size;
         tail_d = tail_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(alloc) - CW'(ret);
      if (flush_in) begin
         tail_d = cm_d;
         cnt_d = '0;
         for (int i = 0; i < DEPTH; i++) begin
            v_d[i] = v_d[i] && cmt_d[i];
            cnt_d = cnt_d + CW'(v_d[i]);
         end
      end
      // An in-flight flushed load must still finish its handshake, but its slot may be reused.
      kill_now = kill_q || (flush_in && !cmt_d[idx_q]);
      if (state_q == IDLE) begin
         if (found && !flush_in) begin
            if (fwd) begin
               cpl_d[sel] = 1'b1;
               ldv_d = 1'b1;
               ldd_d = ext(data_q[fsrc], size_q[sel], zx_q[sel]);
            end else begin
               state_d = WAIT_ACK; idx_d = sel; kill_d = 1'b0;
               wr_d = !ld_q[sel]; a_d = addr_q[sel]; wd_d = data_q[sel]; sz_d = size_q[sel];
            end
         end
      end else if (dc_ack) begin
         state_d = IDLE;
         kill_d = 1'b0;
         if (!kill_now) begin
            cpl_d[idx_q] = 1'b1;
            ldv_d = ld_q[idx_q];
            ldd_d = ld_q[idx_q] ? dc_rdata : ldd_q;
            ldf_d = ld_q[idx_q] && dc_fault;
         end
      end else kill_d = kill_now;
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         v_q <= '0; cmt_q <= '0; cpl_q <= '0;
         head_q <= '0; tail_q <= '0; cm_q <= '0; cnt_q <= '0; idx_q <= '0;
         state_q <= IDLE; kill_q <= 1'b0;
         ldv_q <= 1'b0; ldf_q <= 1'b0; ldd_q <= '0;
      end else begin
         v_q <= v_d; cmt_q <= cmt_d; cpl_q <= cpl_d;
         head_q <= head_d; tail_q <= tail_d; cm_q <= cm_d; cnt_q <= cnt_d; idx_q <= idx_d;
         state_q <= state_d; kill_q <= kill_d;
         ldv_q <= ldv_d; ldf_q <= ldf_d; ldd_q <= ldd_d;
      end
   end

   always_ff @(posedge clk_in) begin
      ld_q <= ld_d; zx_q <= zx_d; addr_q <= addr_d; data_q <= data_d; size_q <= size_d;
      wr_q <= wr_d; a_q <= a_d; wd_q <= wd_d; sz_q <= sz_d;
   end
endmodule

// File: tb/tb_ls_queue_fwd.sv
// tb_ls_queue_fwd: directed scenarios for ls_queue_fwd with inline hand-computed checks.
module tb_ls_queue_fwd;
   logic        clk = 1'b0;
   logic        reset_in = 1'b1;
   logic        enq_valid = 1'b0, enq_is_ld = 1'b0, enq_zero_ext = 1'b0;
   logic [31:0] enq_addr = '0, enq_data = '0;
   logic [2:0]  enq_size = 3'd4;
   logic        cm_valid = 1'b0, flush_in = 1'b0;
   logic        enq_rdy, dc_req, dc_wr;
   logic [31:0] dc_addr, dc_wdata;
   logic [2:0]  dc_size;
   logic        dc_ack = 1'b0, dc_fault = 1'b0;
   logic [31:0] dc_rdata = '0;
   logic        ld_valid, ld_fault;
   logic [31:0] ld_data;
   int errors = 0;
   int checks = 0;

   ls_queue_fwd dut (
      .clk_in(clk), .reset_in(reset_in),
      .enq_valid(enq_valid), .enq_rdy(enq_rdy), .enq_is_ld(enq_is_ld), .enq_addr(enq_addr),
      .enq_data(enq_data), .enq_size(enq_size), .enq_zero_ext(enq_zero_ext),
      .cm_valid(cm_valid), .flush_in(flush_in),
      .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_size(dc_size),
      .dc_ack(dc_ack), .dc_rdata(dc_rdata), .dc_fault(dc_fault),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_fault(ld_fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_in = 1'b1; enq_valid = 1'b0; cm_valid = 1'b0; flush_in = 1'b0;
      dc_ack = 1'b0; dc_fault = 1'b0; dc_rdata = '0;
      step(); step();
      reset_in = 1'b0;
   endtask

   task automatic enq(input logic ld, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] s, input logic z);
      enq_valid = 1'b1; enq_is_ld = ld; enq_addr = a; enq_data = d; enq_size = s; enq_zero_ext = z;
      step();
      enq_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (dc_req !== 1'b0) begin errors++; $display("FAIL reset_dc_req got %b want 0", dc_req); end
      checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL reset_ld_valid got %b want 0", ld_valid); end
      checks++; if (ld_fault !== 1'b0) begin errors++; $display("FAIL reset_ld_fault got %b want 0", ld_fault); end
      checks++; if (enq_rdy !== 1'b1) begin errors++; $display("FAIL reset_enq_rdy got %b want 1", enq_rdy); end
      checks++; if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", dut.cnt_q); end
   endtask

   task automatic test_fwd_sign();
      do_reset();
      enq(1'b0, 32'h100, 32'hDEADBEEF, 3'd4, 1'b0);
      enq(1'b1, 32'h100, 32'h0, 3'd1, 1'b0);
      step();
      checks++; if (ld_valid !== 1'b1) begin errors++; $display("FAIL fwd_sb_valid got %b want 1", ld_valid); end
      checks++; if (ld_data !== 32'hFFFFFFEF) begin errors++; $display("FAIL fwd_sb_data got %h want ffffffef", ld_data); end
      checks++; if (dc_req !== 1'b0) begin errors++; $display("FAIL fwd_sb_no_req got %b want 0", dc_req); end
      step();
      checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL fwd_sb_pulse got %b want 0", ld_valid); end
   endtask

   task automatic test_fwd_ext();
      do_reset();
      enq(1'b0, 32'h300, 32'h12348001, 3'd4, 1'b0);
      enq(1'b1, 32'h300, 32'h0, 3'd2, 1'b1);
      enq(1'b1, 32'h300, 32'h0, 3'd2, 1'b0);
      checks++; if (ld_data !== 32'h00008001 || ld_valid !== 1'b1) begin errors++; $display("FAIL fwd_zh got %b/%h want 1/00008001", ld_valid, ld_data); end
      step();
      checks++; if (ld_data !== 32'hFFFF8001 || ld_valid !== 1'b1) begin errors++; $display("FAIL fwd_sh got %b/%h want 1/ffff8001", ld_valid, ld_data); end
      enq(1'b1, 32'h302, 32'h0, 3'd1, 1'b1);
      step(); step();
      checks++; if (ld_valid !== 1'b0 || dc_req !== 1'b0) begin errors++; $display("FAIL offset_stall got %b/%b want 0/0", ld_valid, dc_req); end
   endtask

   task automatic test_stall();
      do_reset();
      enq(1'b0, 32'h100, 32'h000000AB, 3'd1, 1'b0);
      enq(1'b1, 32'h100, 32'h0, 3'd4, 1'b0);
      step(); step();
      checks++; if (dc_req !== 1'b0 || ld_valid !== 1'b0) begin errors++; $display("FAIL stall_idle got %b/%b want 0/0", dc_req, ld_valid); end
      cm_valid = 1'b1; step(); cm_valid = 1'b0;
      step();
      checks++; if ({dc_req, dc_wr, dc_addr, dc_wdata, dc_size} !== {1'b1, 1'b1, 32'h100, 32'hAB, 3'd1}) begin
         errors++; $display("FAIL stall_store_req got %b %b %h %h %0d want 1 1 100 ab 1", dc_req, dc_wr, dc_addr, dc_wdata, dc_size); end
      dc_ack = 1'b1; step(); dc_ack = 1'b0;
      checks++; if (dc_req !== 1'b0 || ld_valid !== 1'b0) begin errors++; $display("FAIL stall_store_ack got %b/%b want 0/0", dc_req, ld_valid); end
      step();
      checks++; if (dut.cnt_q !== 4'd1 || dc_req !== 1'b0) begin errors++; $display("FAIL stall_retire got %0d/%b want 1/0", dut.cnt_q, dc_req); end
      step();
      checks++; if ({dc_req, dc_wr, dc_addr, dc_size} !== {1'b1, 1'b0, 32'h100, 3'd4}) begin
         errors++; $display("FAIL stall_load_req got %b %b %h %0d want 1 0 100 4", dc_req, dc_wr, dc_addr, dc_size); end
      dc_rdata = 32'hCAFEF00D; dc_ack = 1'b1; step(); dc_ack = 1'b0;
      checks++; if (ld_valid !== 1'b1 || ld_data !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_load_data got %b/%h want 1/cafef00d", ld_valid, ld_data); end
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < 8; i++) enq(1'b0, 32'h400 + 32'(4 * i), 32'(i), 3'd4, 1'b0);
      checks++; if (enq_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got %b want 0", enq_rdy); end
      checks++; if (dut.tail_q !== 3'd0) begin errors++; $display("FAIL full_tail_wrap got %0d want 0", dut.tail_q); end
      enq(1'b0, 32'h600, 32'h0, 3'd4, 1'b0);
      checks++; if (dut.cnt_q !== 4'd8) begin errors++; $display("FAIL full_drop got %0d want 8", dut.cnt_q); end
      cm_valid = 1'b1; step(); cm_valid = 1'b0;
      step();
      checks++; if (dc_req !== 1'b1 || dc_addr !== 32'h400) begin errors++; $display("FAIL full_head_req got %b/%h want 1/400", dc_req, dc_addr); end
      dc_ack = 1'b1; step(); dc_ack = 1'b0;
      checks++; if (enq_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_ack got %b want 0", enq_rdy); end
      step();
      checks++; if (enq_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_retire got %b want 1", enq_rdy); end
      enq(1'b0, 32'h500, 32'h0, 3'd4, 1'b0);
      checks++; if (dut.tail_q !== 3'd1 || enq_rdy !== 1'b0) begin errors++; $display("FAIL full_refill got %0d/%b want 1/0", dut.tail_q, enq_rdy); end
   endtask

   task automatic test_flush();
      do_reset();
      enq(1'b1, 32'h700, 32'h0, 3'd4, 1'b0);
      enq(1'b1, 32'h704, 32'h0, 3'd4, 1'b0);
      enq(1'b1, 32'h708, 32'h0, 3'd4, 1'b0);
      checks++; if (dc_req !== 1'b1 || dc_addr !== 32'h700) begin errors++; $display("FAIL flush_req got %b/%h want 1/700", dc_req, dc_addr); end
      flush_in = 1'b1; step(); flush_in = 1'b0;
      checks++; if (dut.cnt_q !== 4'd0 || dc_req !== 1'b1) begin errors++; $display("FAIL flush_count got %0d/%b want 0/1", dut.cnt_q, dc_req); end
      dc_rdata = 32'h11111111; dc_ack = 1'b1; step(); dc_ack = 1'b0;
      checks++; if (ld_valid !== 1'b0 || dc_req !== 1'b0) begin errors++; $display("FAIL flush_discard got %b/%b want 0/0", ld_valid, dc_req); end
      step();
      checks++; if (ld_valid !== 1'b0 || dc_req !== 1'b0) begin errors++; $display("FAIL flush_quiet got %b/%b want 0/0", ld_valid, dc_req); end
   endtask

   task automatic test_fault();
      do_reset();
      enq(1'b1, 32'h200, 32'h0, 3'd4, 1'b0);
      step();
      checks++; if (dc_req !== 1'b1 || dc_addr !== 32'h200) begin errors++; $display("FAIL fault_req got %b/%h want 1/200", dc_req, dc_addr); end
      dc_rdata = 32'h00001234; dc_fault = 1'b1; dc_ack = 1'b1; step(); dc_ack = 1'b0; dc_fault = 1'b0;
      checks++; if ({ld_valid, ld_fault, ld_data} !== {1'b1, 1'b1, 32'h1234}) begin
         errors++; $display("FAIL fault_pulse got %b %b %h want 1 1 00001234", ld_valid, ld_fault, ld_data); end
      step();
      checks++; if (ld_valid !== 1'b0 || dut.cnt_q !== 4'd1) begin errors++; $display("FAIL fault_hold got %b/%0d want 0/1", ld_valid, dut.cnt_q); end
      cm_valid = 1'b1; step(); cm_valid = 1'b0;
      step();
      checks++; if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL fault_retire got %0d want 0", dut.cnt_q); end
   endtask

   task automatic test_reset_wait();
      do_reset();
      enq(1'b1, 32'h800, 32'h0, 3'd4, 1'b0);
      step();
      checks++; if (dc_req !== 1'b1) begin errors++; $display("FAIL rw_req got %b want 1", dc_req); end
      reset_in = 1'b1; step(); reset_in = 1'b0;
      checks++; if ({dc_req, enq_rdy, dut.cnt_q} !== {1'b0, 1'b1, 4'd0}) begin
         errors++; $display("FAIL rw_state got %b %b %0d want 0 1 0", dc_req, enq_rdy, dut.cnt_q); end
   endtask

   initial begin
      test_reset();
      test_fwd_sign();
      test_fwd_ext();
      test_stall();
      test_full_wrap();
      test_flush();
      test_fault();
      test_reset_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
